// File: rtl/neural_pkg.sv
// Shared types and constants for the neural_stage result path.
// float_24_8 word layout, exponent field helpers and the collector FSM states.
package neural_pkg;

  typedef logic [31:0] float_24_8_t;

  localparam int unsigned FLT_EXP_MSB = 30;
  localparam int unsigned FLT_EXP_LSB = 23;
  localparam logic [7:0]  FLT_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DRAIN
  } collector_state_t;

  // True for Inf/NaN encodings (exponent field all ones).
  function automatic logic flt_exp_is_max(float_24_8_t w);
    return w[FLT_EXP_MSB:FLT_EXP_LSB] == FLT_EXP_MAX;
  endfunction

endpackage

// File: rtl/neural_stage_collector_if.sv
// Result stream of the collector: valid/ready handshake with data and frame index.
// master = collector side, slave = downstream consumer.
interface neural_stage_collector_if #(
  parameter int unsigned IDX_W = 16
);
  import neural_pkg::*;

  logic              out_valid;
  logic              out_ready;
  float_24_8_t       out_data;
  logic [IDX_W-1:0]  out_index;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    output out_ready
  );

endinterface

// File: rtl/neural_sync_fifo.sv
// Registered first-word-fall-through FIFO. A push into a full FIFO succeeds only
// when a pop happens on the same edge; otherwise it is dropped. Head reads zero
// while empty so the outputs have a defined value after reset.
module neural_sync_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH[LW-1:0]);
  assign level_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + LW'(do_push) - LW'(do_pop);
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/neural_stage_collector.sv
// Sink for the neural_stage output stream: delays `first` by the stage latency,
// captures one float_24_8 result per tracked frame, tags it with a frame index
// and buffers it in a FWFT FIFO drained over a valid/ready interface.
// Optional: define NEURAL_COLLECT_NAN_CHECK_EN to add the sticky nan_seen output.
module neural_stage_collector
  import neural_pkg::*;
#(
  parameter int unsigned LATENCY = 18,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned IDX_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       first,
  input  float_24_8_t                stage_data,
  neural_stage_collector_if.master   out_if,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       busy
`ifdef NEURAL_COLLECT_NAN_CHECK_EN
  ,
  output logic                       nan_seen
`endif
);

  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned EW = 32 + IDX_W;

  collector_state_t   state_q, state_d;
  logic [CW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [LATENCY-1:0] dly_q, dly_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;

  logic               track_in;
  logic               cap;
  logic               capture;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic [EW-1:0]      head;

  // Only `first` pulses belonging to a frame we intend to keep enter the delay
  // line, so tails from before arming never surface as captures.
  assign track_in = first && (((state_q == ARMED) && enable) ||
                              (state_q == RUN) ||
                              ((state_q == DRAIN) && enable));
  assign cap      = dly_q[LATENCY-1];
  assign capture  = cap && ((state_q == RUN) || (state_q == DRAIN));
  assign pop      = out_if.out_valid && out_if.out_ready;

  // Delay line, frame index and sticky overflow next-state.
  always_comb begin
    dly_d = {dly_q[LATENCY-2:0], track_in};
    idx_d = idx_q + IDX_W'(capture);
    ovf_d = ovf_q | (capture && fifo_full && !pop);
  end

  // Collector FSM next-state; DRAIN lasts LATENCY cycles to flush tracked pulses.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ARMED;
      end
      ARMED: begin
        if (!enable)    state_d = IDLE;
        else if (first) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (drain_cnt_q == CW'(LATENCY - 1)) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      dly_q       <= '0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
    end
  end

  neural_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (capture),
    .push_data_i ({idx_q, stage_data}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = head[31:0];
  assign out_if.out_index = head[32 +: IDX_W];
  assign overflow         = ovf_q;
  assign busy             = (state_q != IDLE) || (level != '0);

`ifdef NEURAL_COLLECT_NAN_CHECK_EN
  logic nan_q, nan_d;

  // Flag any captured Inf/NaN word; the word itself is pushed unchanged.
  always_comb begin
    nan_d = nan_q | (capture && flt_exp_is_max(stage_data));
  end

  // Sticky NaN flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nan_q <= 1'b0;
    else        nan_q <= nan_d;
  end

  assign nan_seen = nan_q;
`endif

endmodule

// File: tb/tb_neural_stage_collector.sv
// Directed bench for neural_stage_collector. Cycle c is the period after the
// c-th rising edge following reset release; inputs change 1 ns after the edge
// and outputs are sampled on the falling edge.
module tb_neural_stage_collector;
  import neural_pkg::*;

  localparam int unsigned LATENCY = 18;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned IDX_W   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        first = 1'b0;
  logic [31:0] stage_data = '0;
  logic [3:0]  level;
  logic        overflow;
  logic        busy;
`ifdef NEURAL_COLLECT_NAN_CHECK_EN
  logic        nan_seen;
`endif

  int checks = 0;
  int errors = 0;

  neural_stage_collector_if #(.IDX_W(IDX_W)) out_if ();

  neural_stage_collector #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .first      (first),
    .stage_data (stage_data),
    .out_if     (out_if),
    .level      (level),
    .overflow   (overflow),
    .busy       (busy)
`ifdef NEURAL_COLLECT_NAN_CHECK_EN
    ,
    .nan_seen   (nan_seen)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic pulse_at(int c, int start, int period, int count);
    return (c >= start) && (((c - start) % period) == 0) && (((c - start) / period) < count);
  endfunction

  // Hold reset for three cycles, release 1 ns after an edge; returns at cycle 0.
  task automatic go_reset();
    enable = 1'b0;
    first = 1'b0;
    stage_data = '0;
    out_if.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    out_if.out_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", out_if.out_valid); end
    checks++; if (out_if.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h exp 0", out_if.out_data); end
    checks++; if (out_if.out_index !== 16'h0) begin errors++; $display("FAIL reset_index: got %0h exp 0", out_if.out_index); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b exp 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
  endtask

  task automatic test_basic_capture();
    go_reset();
    enable = 1'b1;
    out_if.out_ready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      first = pulse_at(c, 10, 16, 3);
      stage_data = 32'(c);
      @(negedge clk);
      if (c == 28) begin
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency c=%0d: valid %0b exp 0", c, out_if.out_valid); end
      end
      if (c == 29 || c == 45 || c == 61) begin
        checks++; if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid c=%0d: got %0b exp 1", c, out_if.out_valid); end
        checks++; if (out_if.out_data !== 32'(c - 1)) begin errors++; $display("FAIL basic_data c=%0d: got %0d exp %0d", c, out_if.out_data, c - 1); end
        checks++; if (out_if.out_index !== 16'((c - 29) / 16)) begin errors++; $display("FAIL basic_index c=%0d: got %0d exp %0d", c, out_if.out_index, (c - 29) / 16); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    go_reset();
    enable = 1'b1;
    out_if.out_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      first = pulse_at(c, 2, 4, 10);
      stage_data = 32'(c);
      @(negedge clk);
      if (c == 49) begin
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level8: got %0d exp 8", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b exp 0", overflow); end
      end
      if (c == 53) begin
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level_sat: got %0d exp 8", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b exp 1", overflow); end
      end
      @(posedge clk); #1;
    end
    first = 1'b0;
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid k=%0d: got %0b exp 1", k, out_if.out_valid); end
      checks++; if (out_if.out_index !== 16'(k)) begin errors++; $display("FAIL ovf_drain_index: got %0d exp %0d", out_if.out_index, k); end
      checks++; if (out_if.out_data !== 32'(20 + 4 * k)) begin errors++; $display("FAIL ovf_drain_data k=%0d: got %0d exp %0d", k, out_if.out_data, 20 + 4 * k); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: valid %0b exp 0", out_if.out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b exp 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    go_reset();
    enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      first = pulse_at(c, 2, 4, 9);
      stage_data = 32'(c);
      out_if.out_ready = (c == 52);
      @(negedge clk);
      if (c == 52) begin
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL pp_pre_level: got %0d exp 8", level); end
      end
      if (c == 53) begin
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL pp_level: got %0d exp 8", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %0b exp 0", overflow); end
        checks++; if (out_if.out_index !== 16'd1) begin errors++; $display("FAIL pp_head_index: got %0d exp 1", out_if.out_index); end
        checks++; if (out_if.out_data !== 32'd24) begin errors++; $display("FAIL pp_head_data: got %0d exp 24", out_if.out_data); end
      end
      @(posedge clk); #1;
    end
    first = 1'b0;
    out_if.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (out_if.out_index !== 16'(k)) begin errors++; $display("FAIL pp_drain_index: got %0d exp %0d", out_if.out_index, k); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_enable_drop();
    go_reset();
    out_if.out_ready = 1'b1;
    for (int c = 0; c < 55; c++) begin
      enable = (c < 7);
      first = (c == 5) || (c == 15) || (c == 30);
      stage_data = 32'(c);
      @(negedge clk);
      if (c == 24) begin
        checks++; if (out_if.out_valid !== 1'b1) begin errors++; $display("FAIL drop_valid: got %0b exp 1", out_if.out_valid); end
        checks++; if (out_if.out_data !== 32'd23) begin errors++; $display("FAIL drop_data: got %0d exp 23", out_if.out_data); end
        checks++; if (out_if.out_index !== 16'd0) begin errors++; $display("FAIL drop_index: got %0d exp 0", out_if.out_index); end
      end else begin
        checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL drop_no_extra c=%0d: valid %0b exp 0", c, out_if.out_valid); end
      end
      if (c == 25) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_drain: got %0b exp 1", busy); end
      end
      if (c == 27) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %0b exp 0", busy); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    go_reset();
    enable = 1'b1;
    out_if.out_ready = 1'b0;
    for (int c = 0; c < 37; c++) begin
      first = pulse_at(c, 2, 4, 6);
      stage_data = 32'(c);
      @(negedge clk);
      @(posedge clk); #1;
    end
    first = 1'b0;
    @(negedge clk);
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL arst_pre_level: got %0d exp 5", level); end
    #2 reset = 1'b0;
    #1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL arst_level: got %0d exp 0", level); end
    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b exp 0", out_if.out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow: got %0b exp 0", overflow); end
    checks++; if (out_if.out_data !== 32'h0) begin errors++; $display("FAIL arst_data: got %0h exp 0", out_if.out_data); end
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_capture c=%0d: valid %0b exp 0", c, out_if.out_valid); end
      @(posedge clk); #1;
    end
  endtask

`ifdef NEURAL_COLLECT_NAN_CHECK_EN
  task automatic test_nan();
    go_reset();
    enable = 1'b1;
    out_if.out_ready = 1'b1;
    for (int c = 0; c < 23; c++) begin
      first = (c == 2);
      stage_data = (c == 20) ? 32'h7F80_0000 : 32'(c);
      @(negedge clk);
      if (c == 20) begin
        checks++; if (nan_seen !== 1'b0) begin errors++; $display("FAIL nan_early: got %0b exp 0", nan_seen); end
      end
      if (c == 21) begin
        checks++; if (nan_seen !== 1'b1) begin errors++; $display("FAIL nan_seen: got %0b exp 1", nan_seen); end
        checks++; if (out_if.out_data !== 32'h7F80_0000) begin errors++; $display("FAIL nan_data: got %0h exp 7f800000", out_if.out_data); end
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    out_if.out_ready = 1'b0;
    test_reset();
    test_basic_capture();
    test_overflow();
    test_full_push_pop();
    test_enable_drop();
    test_async_reset();
`ifdef NEURAL_COLLECT_NAN_CHECK_EN
    test_nan();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neural_stage_collector.md
Name: neural_stage_collector

Overview:
Synthesizable sink for the neural_stage output stream. It re-times the `first` frame pulse by the stage pipeline latency and captures one float_24_8 result per frame. Each result is tagged with a frame index and buffered in a small FIFO. The FIFO drains through a valid/ready interface to the next layer or to a host readback path.

Parameters:
LATENCY, 18, cycles from `first` to the valid neural_stage_data_out sample (2..63)
DEPTH, 8, FIFO entries (power of two, 2..64)
IDX_W, 16, frame index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  capture enable
first  in  1  frame-start pulse, same signal driven into neural_stage
stage_data  in  32  neural_stage_data_out (float_24_8)
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_data  out  32  captured result
out_index  out  IDX_W  frame index of out_data
level  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a capture was dropped
busy  out  1  state != IDLE or level != 0

Behaviour:
- Reset, asynchronous on falling reset:
  - state=IDLE; delay line cleared; FIFO pointers=0; level=0.
  - out_valid=0; out_data=0; out_index=0; overflow=0; frame index=0.
  - Reset mid-frame discards any in-flight pulses and all buffered data.
- Delay line: LATENCY-bit shift register of `first`, shifted every cycle in every state. The tap is `cap` = first delayed by exactly LATENCY cycles.
- FSM:
  - IDLE: go to ARMED when enable=1.
  - ARMED: ignore `cap`. On the first `first`=1 while enable=1, go to RUN. This pulse's result is captured. Earlier tails are never captured. If enable=0, go to IDLE.
  - RUN:
    - On `cap`=1, capture stage_data together with the current frame index, then increment the index (wraps modulo 2^IDX_W).
    - On enable=0, go to DRAIN.
  - DRAIN:
    - Continue capturing `cap` pulses from frames whose `first` was seen in RUN. This is tracked as an outstanding-frame count of at most ceil(LATENCY/1) pulses in the delay line. Simplest compliant form: stay in DRAIN for LATENCY cycles, capturing any `cap`.
    - Then go to IDLE. enable=1 during DRAIN goes back to RUN.
- Capture timing: stage_data is sampled on the same edge where `cap`=1. The entry becomes visible with out_valid=1 on the following cycle. Capture-to-out_valid latency is 1 cycle when the FIFO was empty.
- FIFO:
  - Standard registered FIFO with first-word-fall-through. out_data and out_index are valid whenever out_valid=1.
  - A pop happens when out_valid && out_ready.
  - A push and a pop in the same cycle when full are allowed: the push succeeds and level stays DEPTH.
  - A push when full with no pop is dropped; overflow is set and remains set until reset. The frame index still increments.
  - A pop when empty is a no-op.
- level reflects pushes and pops registered on the same edge.
- out_valid is not gated by enable; buffered data always drains.

Optional Feature:
NEURAL_COLLECT_NAN_CHECK_EN:
- Defined:
  - Adds output `nan_seen` (1 bit, sticky, reset 0).
  - It sets when a captured word has exponent bits [30:23] == 8'hFF.
  - The word is still pushed unchanged.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package neural_pkg: float_24_8 typedef, exponent field constants (FLT_EXP_MSB=30, FLT_EXP_LSB=23, FLT_EXP_MAX=8'hFF), FSM state enum collector_state_t {IDLE, ARMED, RUN, DRAIN}.
- One sub-module: neural_sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, level, head data). The collector instantiates it with WIDTH=32+IDX_W.

Test Plan:
- Basic capture: reset low 3 cycles then high; enable=1; `first` every 16 cycles from cycle 10; stage_data=counter value; out_ready=1.
  -> Captures occur at cycles 28, 44, 60. out_data=28/44/60 one cycle later; out_index=0,1,2.
- Backpressure/overflow: out_ready=0; 10 frames.
  -> level saturates at 8; overflow=1 after the 9th capture. Then out_ready=1 drains indices 0..7 in order.
- Full with simultaneous push/pop: fill to 8; assert out_ready in the capture cycle.
  -> level stays 8; overflow stays 0.
- Enable drop: enable=0 two cycles after a `first` in RUN.
  -> That frame is still captured at +18; FSM returns to IDLE; later `first` pulses are not captured.
- Async reset: assert reset mid-frame with level=5.
  -> Outputs clear immediately without a clock edge (level=0, out_valid=0, overflow=0). The pending `cap` is not captured after release.
- With NEURAL_COLLECT_NAN_CHECK_EN: drive stage_data=32'h7F800000 at a capture.
  -> nan_seen=1, and out_data=32'h7F800000.
